// File: rtl/puncturer.sv
// Puncturer for a serial rate-1/2 convolutional code stream (A/B interleaved, A first).
// Supports rates 1/2, 2/3 and 3/4; define PUNCT_STATS_EN to add the Drop_count output.
module puncturer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        In_bit,
  input  logic        In_valid,
  input  logic        In_start,
  input  logic        In_last,
  input  logic [1:0]  Rate,
  output logic        Out_bit,
  output logic        Out_valid,
  output logic        Out_start,
  output logic        Align_err
`ifdef PUNCT_STATS_EN
  ,
  output logic [15:0] Drop_count
`endif
);

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned CNT_W   = 16;

  localparam logic [1:0] RATE_1_2  = 2'b00;
  localparam logic [1:0] RATE_2_3  = 2'b01;
  localparam logic [1:0] RATE_3_4  = 2'b10;
  localparam logic [1:0] RATE_RSVD = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e               state_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [1:0]           rate_q;
  logic                 out_bit_q;
  logic                 out_valid_q;
  logic                 out_start_q;
  logic                 align_err_q;

  logic                 accept_c;
  logic [1:0]           eff_rate_c;
  logic [PHASE_W-1:0]   eff_phase_c;
  logic [PHASE_W-1:0]   last_phase_c;
  logic                 keep_c;
  logic [PHASE_W-1:0]   phase_d;

  // Highest phase index of the puncturing period for a given rate.
  function automatic logic [PHASE_W-1:0] last_phase(input logic [1:0] r);
    case (r)
      RATE_2_3: last_phase = PHASE_W'(3);
      RATE_3_4: last_phase = PHASE_W'(5);
      default:  last_phase = PHASE_W'(1);
    endcase
  endfunction

  // Keep mask: 2/3 drops B1 (phase 3); 3/4 drops B1 and A2 (phases 3 and 4).
  function automatic logic keep_bit(input logic [1:0] r, input logic [PHASE_W-1:0] p);
    case (r)
      RATE_2_3: keep_bit = (p != PHASE_W'(3));
      RATE_3_4: keep_bit = (p != PHASE_W'(3)) && (p != PHASE_W'(4));
      default:  keep_bit = 1'b1;
    endcase
  endfunction

  // Resolve which rate/phase applies to the bit presented this cycle.
  always_comb begin
    accept_c    = 1'b0;
    eff_rate_c  = rate_q;
    eff_phase_c = phase_q;
    if (In_valid) begin
      if (In_start) begin
        accept_c    = 1'b1;
        eff_rate_c  = (Rate == RATE_RSVD) ? RATE_1_2 : Rate;
        eff_phase_c = '0;
      end else if (state_q == ACTIVE) begin
        accept_c = 1'b1;
      end
    end
    last_phase_c = last_phase(eff_rate_c);
    keep_c       = keep_bit(eff_rate_c, eff_phase_c);
    phase_d      = (eff_phase_c == last_phase_c) ? '0 : PHASE_W'(eff_phase_c + PHASE_W'(1));
  end

  // Frame state machine and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      rate_q      <= RATE_1_2;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      align_err_q <= 1'b0;
      if (accept_c) begin
        rate_q      <= eff_rate_c;
        out_valid_q <= keep_c;
        out_start_q <= In_start;
        if (keep_c) begin
          out_bit_q <= In_bit;
        end
        if (In_last) begin
          state_q     <= IDLE;
          phase_q     <= '0;
          align_err_q <= (eff_phase_c != last_phase_c);
        end else begin
          state_q <= ACTIVE;
          phase_q <= phase_d;
        end
      end
    end
  end

  assign Out_bit   = out_bit_q;
  assign Out_valid = out_valid_q;
  assign Out_start = out_start_q;
  assign Align_err = align_err_q;

`ifdef PUNCT_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q;

  // Dropped-bit counter, cleared by each frame start and saturating at all ones.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      drop_cnt_q <= '0;
    end else if (accept_c) begin
      if (In_start) begin
        drop_cnt_q <= '0;
      end else if (!keep_c && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_q <= CNT_W'(drop_cnt_q + CNT_W'(1));
      end
    end
  end

  assign Drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_puncturer.sv
// Directed self-checking bench for puncturer; Drop_count checks compile in with PUNCT_STATS_EN.
module tb_puncturer;

  logic        Clock;
  logic        Reset;
  logic        In_bit;
  logic        In_valid;
  logic        In_start;
  logic        In_last;
  logic [1:0]  Rate;
  logic        Out_bit;
  logic        Out_valid;
  logic        Out_start;
  logic        Align_err;
`ifdef PUNCT_STATS_EN
  logic [15:0] Drop_count;
`endif

  int checks = 0;
  int errors = 0;

  puncturer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .In_bit    (In_bit),
    .In_valid  (In_valid),
    .In_start  (In_start),
    .In_last   (In_last),
    .Rate      (Rate),
    .Out_bit   (Out_bit),
    .Out_valid (Out_valid),
    .Out_start (Out_start),
    .Align_err (Align_err)
`ifdef PUNCT_STATS_EN
    ,
    .Drop_count(Drop_count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Present one input cycle at a falling edge; returns at the next falling edge,
  // where the registered response to that cycle is visible.
  task automatic drive(input logic b, input logic v, input logic s, input logic l,
                       input logic [1:0] r);
    In_bit   = b;
    In_valid = v;
    In_start = s;
    In_last  = l;
    Rate     = r;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    checks++;
    if ({Out_bit, Out_valid, Out_start, Align_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {Out_bit, Out_valid, Out_start, Align_err});
    end
`ifdef PUNCT_STATS_EN
    checks++;
    if (Drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_count: got %0d expected 0", Drop_count);
    end
`endif
    In_valid = 1'b0;
    In_start = 1'b0;
    Reset    = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    checks++;
    if (Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got %b expected 0", Out_valid);
    end
  endtask

  task automatic test_rate_half();
    logic [0:3] ib;
    ib = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      drive(ib[i], 1'b1, i == 0, i == 3, 2'b00);
      checks++;
      if ({Out_valid, Out_bit, Out_start, Align_err} !== {1'b1, ib[i], i == 0, 1'b0}) begin
        errors++;
        $display("FAIL half[%0d] v/b/s/e: got %b expected %b", i,
                 {Out_valid, Out_bit, Out_start, Align_err}, {1'b1, ib[i], i == 0, 1'b0});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    checks++;
    if (Out_valid !== 1'b0 || Out_bit !== 1'b1) begin
      errors++;
      $display("FAIL half_after v/b: got %b%b expected 01", Out_valid, Out_bit);
    end
  endtask

  task automatic test_rate_3_4();
    logic [0:11] ib;
    logic [0:11] ev;
    logic [0:11] eb;
    ib = 12'b101101_001011;
    ev = 12'b111001_111001;
    eb = 12'b101111_001111;
    for (int i = 0; i < 12; i++) begin
      drive(ib[i], 1'b1, i == 0, i == 11, 2'b10);
      checks++;
      if ({Out_valid, Out_bit, Out_start, Align_err} !== {ev[i], eb[i], i == 0, 1'b0}) begin
        errors++;
        $display("FAIL r34[%0d] v/b/s/e: got %b expected %b", i,
                 {Out_valid, Out_bit, Out_start, Align_err}, {ev[i], eb[i], i == 0, 1'b0});
      end
    end
`ifdef PUNCT_STATS_EN
    checks++;
    if (Drop_count !== 16'd4) begin
      errors++;
      $display("FAIL r34_drop_count: got %0d expected 4", Drop_count);
    end
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
  endtask

  task automatic test_gaps_2_3();
    logic [0:7] ib;
    logic [0:7] ev;
    logic [0:7] eb;
    int         n_out;
    ib    = 8'b11010110;
    ev    = 8'b11101110;
    eb    = 8'b11000111;
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      drive(ib[i], 1'b1, i == 0, i == 7, 2'b01);
      if (Out_valid === 1'b1) n_out++;
      checks++;
      if ({Out_valid, Out_bit, Align_err} !== {ev[i], eb[i], 1'b0}) begin
        errors++;
        $display("FAIL r23_gap[%0d] v/b/e: got %b expected %b", i,
                 {Out_valid, Out_bit, Align_err}, {ev[i], eb[i], 1'b0});
      end
      drive(~ib[i], 1'b0, 1'b0, 1'b0, 2'b10);
      checks++;
      if ({Out_valid, Out_bit} !== {1'b0, eb[i]}) begin
        errors++;
        $display("FAIL r23_gap_hold[%0d] v/b: got %b expected %b", i,
                 {Out_valid, Out_bit}, {1'b0, eb[i]});
      end
    end
    checks++;
    if (n_out != 6) begin
      errors++;
      $display("FAIL r23_gap_count: got %0d expected 6", n_out);
    end
`ifdef PUNCT_STATS_EN
    checks++;
    if (Drop_count !== 16'd2) begin
      errors++;
      $display("FAIL r23_drop_count: got %0d expected 2", Drop_count);
    end
`endif
  endtask

  task automatic test_misaligned();
    logic [0:2] ib;
    ib = 3'b101;
    for (int i = 0; i < 3; i++) begin
      drive(ib[i], 1'b1, i == 0, i == 2, 2'b01);
      checks++;
      if ({Out_valid, Out_bit, Align_err} !== {1'b1, ib[i], i == 2}) begin
        errors++;
        $display("FAIL misalign[%0d] v/b/e: got %b expected %b", i,
                 {Out_valid, Out_bit, Align_err}, {1'b1, ib[i], i == 2});
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
      checks++;
      if ({Out_valid, Align_err} !== 2'b00) begin
        errors++;
        $display("FAIL misalign_after[%0d] v/e: got %b expected 00", i, {Out_valid, Align_err});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid_frame();
    logic [0:3] ib;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
    In_valid = 1'b0;
    In_start = 1'b0;
    Reset    = 1'b1;
    #1;
    checks++;
    if ({Out_bit, Out_valid, Out_start, Align_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got %b expected 0000", {Out_bit, Out_valid, Out_start, Align_err});
    end
    @(negedge Clock);
    Reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    checks++;
    if (Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: got %b expected 0", Out_valid);
    end
    ib = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      drive(ib[i], 1'b1, i == 0, i == 3, 2'b00);
      checks++;
      if ({Out_valid, Out_bit, Out_start, Align_err} !== {1'b1, ib[i], i == 0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset[%0d] v/b/s/e: got %b expected %b", i,
                 {Out_valid, Out_bit, Out_start, Align_err}, {1'b1, ib[i], i == 0, 1'b0});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_rate_change();
    logic [0:5] ib;
    logic [0:5] ev;
    logic [0:5] eb;
    ib = 6'b011010;
    ev = 6'b111001;
    eb = 6'b011110;
    for (int i = 0; i < 6; i++) begin
      drive(ib[i], 1'b1, i == 0, i == 5, (i < 2) ? 2'b10 : 2'b00);
      checks++;
      if ({Out_valid, Out_bit, Align_err} !== {ev[i], eb[i], 1'b0}) begin
        errors++;
        $display("FAIL rate_change[%0d] v/b/e: got %b expected %b", i,
                 {Out_valid, Out_bit, Align_err}, {ev[i], eb[i], 1'b0});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_restart();
    logic [0:6] ib;
    logic [0:6] ev;
    logic [0:6] es;
    logic [0:6] eb;
    ib = 7'b1010110;
    ev = 7'b1111110;
    es = 7'b1001000;
    eb = 7'b1010111;
    for (int i = 0; i < 7; i++) begin
      drive(ib[i], 1'b1, es[i], i == 6, (i < 3) ? 2'b10 : 2'b01);
      checks++;
      if ({Out_valid, Out_bit, Out_start, Align_err} !== {ev[i], eb[i], es[i], 1'b0}) begin
        errors++;
        $display("FAIL restart[%0d] v/b/s/e: got %b expected %b", i,
                 {Out_valid, Out_bit, Out_start, Align_err}, {ev[i], eb[i], es[i], 1'b0});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_one_bit_and_reserved();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
    checks++;
    if ({Out_valid, Out_bit, Out_start, Align_err} !== 4'b1111) begin
      errors++;
      $display("FAIL one_bit v/b/s/e: got %b expected 1111", {Out_valid, Out_bit, Out_start, Align_err});
    end
`ifdef PUNCT_STATS_EN
    checks++;
    if (Drop_count !== 16'd0) begin
      errors++;
      $display("FAIL one_bit_drop_count: got %0d expected 0", Drop_count);
    end
`endif
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
    checks++;
    if ({Out_valid, Align_err} !== 2'b00) begin
      errors++;
      $display("FAIL one_bit_after v/e: got %b expected 00", {Out_valid, Align_err});
    end
    // Reserved rate code behaves as 1/2: a two-bit frame is fully kept and aligned.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11);
    checks++;
    if ({Out_valid, Out_bit, Out_start, Align_err} !== 4'b1010) begin
      errors++;
      $display("FAIL reserved[0] v/b/s/e: got %b expected 1010", {Out_valid, Out_bit, Out_start, Align_err});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
    checks++;
    if ({Out_valid, Out_bit, Out_start, Align_err} !== 4'b1100) begin
      errors++;
      $display("FAIL reserved[1] v/b/s/e: got %b expected 1100", {Out_valid, Out_bit, Out_start, Align_err});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    Reset    = 1'b1;
    In_bit   = 1'b0;
    In_valid = 1'b0;
    In_start = 1'b0;
    In_last  = 1'b0;
    Rate     = 2'b00;
    @(negedge Clock);
    test_reset();
    test_rate_half();
    test_rate_3_4();
    test_gaps_2_3();
    test_misaligned();
    test_reset_mid_frame();
    test_rate_change();
    test_restart();
    test_one_bit_and_reserved();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puncturer.md
PUNCTURER -- requirements
Module: puncturer

Interface
REQ-001 SHALL have ports Clock (input, 1, rising-edge clock) and Reset (input, 1, asynchronous, active-high reset), listed first.
REQ-002 SHALL have In_bit (input, 1): serial coded bit from the convolutional encoder; A/B alternate, A first.
REQ-003 SHALL have In_valid (input, 1): In_bit is valid this cycle.
REQ-004 SHALL have In_start (input, 1): the current valid bit is the first A bit of a frame.
REQ-005 SHALL have In_last (input, 1): the current valid bit is the final bit of a frame.
REQ-006 SHALL have Rate (input, 2): 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved (treated as 1/2).
REQ-007 SHALL have Out_bit (output, 1): punctured bit.
REQ-008 SHALL have Out_valid (output, 1): Out_bit is valid.
REQ-009 SHALL have Out_start (output, 1): first output bit of a frame.
REQ-010 SHALL have Align_err (output, 1): one-cycle pulse on a misaligned frame end.

Function
REQ-011 SHALL use two states: IDLE and ACTIVE.
REQ-012 In IDLE, SHALL ignore In_valid bits without In_start and produce no output.
REQ-013 On a valid bit with In_start, SHALL latch Rate, set that bit's phase to 0 and enter ACTIVE.
REQ-014 In ACTIVE, In_start SHALL restart the frame: re-latch Rate and set phase to 0.
REQ-015 Rate changes in the middle of a frame SHALL be ignored.
REQ-016 The phase counter SHALL advance only on In_valid and wrap at period-1: period 2 for rate 1/2, 4 for 2/3, 6 for 3/4.
REQ-017 Keep masks by phase:
- rate 1/2: 1,1 (keep all).
- rate 2/3: 1,1,1,0 (drop B1).
- rate 3/4: 1,1,1,0,0,1 (drop B1 and A2).
REQ-018 Out_bit and Out_valid SHALL be registered with 1-cycle latency: Out_valid = In_valid AND keep(phase), and Out_bit = In_bit when kept.
REQ-019 Out_bit SHALL hold its previous value when Out_valid = 0.
REQ-020 Out_start SHALL be registered alongside the phase-0 bit of a frame; phase 0 is always kept.
REQ-021 On a valid bit with In_last, SHALL return to IDLE on the next cycle.
REQ-022 Align_err SHALL pulse 1 cycle later if the In_last bit's phase is not period-1.
REQ-023 In_start and In_last on the same bit SHALL be treated as a one-bit frame: output that bit, raise Align_err, and return to IDLE.
REQ-024 Gaps in In_valid SHALL freeze the phase and state, with no output.

Reset
REQ-025 Reset SHALL asynchronously force:
- state IDLE, phase 0, latched rate 1/2;
- Out_bit, Out_valid, Out_start and Align_err to 0;
- Drop_count (when present) to 0.
REQ-026 Reset asserted in the middle of a frame SHALL abandon the frame; no output until the next In_start.

Configuration
REQ-027 When PUNCT_STATS_EN is defined:
- SHALL add output Drop_count (16 bits);
- Drop_count increments per dropped bit, saturates at 0xFFFF, and clears to 0 on each In_start bit (that bit is never dropped).
REQ-028 When PUNCT_STATS_EN is undefined, the Drop_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Rate 1/2:
- stimulus: start frame, bits 1,0,1,1 with last on the 4th, continuous valid;
- response: Out 1,0,1,1 one cycle delayed, Out_start with the first, Align_err 0.
REQ-030 Rate 3/4:
- stimulus: 12 bits 1,0,1,1,0,1, 0,0,1,0,1,1;
- response: outputs 1,0,1,1, 0,0,1,1 (8 bits), Drop_count = 4.
REQ-031 Rate 2/3:
- stimulus: 8 bits, In_valid toggling every other cycle;
- response: 6 outputs with masks 1,1,1,0 repeated; phase frozen during gaps.
REQ-032 Rate 2/3, misaligned end:
- stimulus: In_last on the 3rd bit;
- response: Align_err pulses once, state returns to IDLE, and a following valid bit without In_start gives no output.
REQ-033 Rate 3/4, reset mid-frame:
- stimulus: Reset after 3 bits;
- response: all outputs 0 immediately; next In_start at rate 1/2 outputs all bits.
REQ-034 Rate change mid-frame:
- stimulus: Rate changes 10 -> 00 at bit 3 of a 3/4 frame;
- response: 3/4 mask still applied.
